// File: rtl/in_filter_reg_cell_pkg.sv
// ----------------------------------------------------------------------------
// in_filter_reg_cell_pkg
// Shared constants for the input filter IO cell and its helpers.
//   FILT_LEN_DEF : default number of consecutive differing synchronized
//                  samples needed before the filtered level follows the pad.
//   CNT_W_DEF    : default width of the filter run counter.
//   SYNC_DEPTH   : number of flops in the pad synchronizer.
// ----------------------------------------------------------------------------
package in_filter_reg_cell_pkg;

    localparam int FILT_LEN_DEF = 4;
    localparam int CNT_W_DEF    = 4;
    localparam int SYNC_DEPTH   = 2;

endpackage

// File: rtl/in_filter_reg_cell_if.sv
// ----------------------------------------------------------------------------
// in_filter_reg_cell_if
// Bundles the pad input, control inputs and the edge-event handshake of the
// input filter cell.
//   master : fabric side, drives IQI/IEN/ISEL/EDGE_RDY/OVF_CLR and observes
//            A2F/EDGE_VLD/EDGE_RISE/EDGE_OVF.
//   slave  : the cell itself, the mirror image of master.
// ----------------------------------------------------------------------------
interface in_filter_reg_cell_if;
    import in_filter_reg_cell_pkg::*;

    logic IQI;
    logic IEN;
    logic ISEL;
    logic A2F;
    logic EDGE_VLD;
    logic EDGE_RISE;
    logic EDGE_RDY;
    logic EDGE_OVF;
    logic OVF_CLR;

    modport master (
        output IQI, IEN, ISEL, EDGE_RDY, OVF_CLR,
        input  A2F, EDGE_VLD, EDGE_RISE, EDGE_OVF
    );

    modport slave (
        input  IQI, IEN, ISEL, EDGE_RDY, OVF_CLR,
        output A2F, EDGE_VLD, EDGE_RISE, EDGE_OVF
    );

endinterface

// File: rtl/in_filter_reg_cell_io_sync2.sv
// ----------------------------------------------------------------------------
// io_sync2
// Plain flop-chain synchronizer for an asynchronous pad input, reusable by
// any IO cell. Depth comes from the shared package (two flops).
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, all stages reset to 0
//   i_d   : asynchronous input
//   o_q   : synchronized output (last stage)
// ----------------------------------------------------------------------------
module io_sync2
    import in_filter_reg_cell_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_DEPTH-1:0] r_syncChain;

    // Shift the pad value through the chain every cycle; stage 0 may go
    // metastable, the later stages give it a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_syncChain <= '0;
        end else begin
            r_syncChain <= {r_syncChain[SYNC_DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_syncChain[SYNC_DEPTH-1];

endmodule

// File: rtl/in_filter_reg_cell.sv
// ----------------------------------------------------------------------------
// in_filter_reg_cell
// Input IO cell: synchronizes a pad, debounces it with a run-length filter
// and reports every filtered level change as a single-entry edge event.
//   FILT_LEN : consecutive differing samples needed to accept a new level
//   CNT_W    : filter counter width (FILT_LEN <= 2**CNT_W-1)
//   IQC      : clock, rising edge
//   QRT      : asynchronous active-low reset
//   bus      : slave side of in_filter_reg_cell_if
//              IQI pad in, IEN capture enable, ISEL output select,
//              A2F level out, EDGE_VLD/EDGE_RISE/EDGE_RDY event handshake,
//              EDGE_OVF sticky overflow, OVF_CLR overflow clear
// ----------------------------------------------------------------------------
module in_filter_reg_cell
    import in_filter_reg_cell_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF,
    parameter int CNT_W    = CNT_W_DEF
)
(
    input  logic                  IQC,
    input  logic                  QRT,
    in_filter_reg_cell_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic             w_syncLevel;
    logic             w_differ;
    logic             w_update;
    logic             w_accept;
    logic             w_overflow;
    logic             r_filtLevel;
    logic [CNT_W-1:0] r_filtCnt;
    logic             r_edgeVld;
    logic             r_edgeRise;
    logic             r_edgeOvf;

    io_sync2 u_sync (
        .clk   (IQC),
        .rst_n (QRT),
        .i_d   (bus.IQI),
        .o_q   (w_syncLevel)
    );

    // A sample only counts towards a level change while capture is enabled;
    // the filtered level moves on the sample that completes the run.
    assign w_differ = bus.IEN && (w_syncLevel != r_filtLevel);
    assign w_update = w_differ && (r_filtCnt == CNT_LAST);

    // Run-length filter. Any agreeing sample or disabled capture restarts
    // the run, so only an unbroken stretch of differing samples gets through.
    always_ff @(posedge IQC or negedge QRT) begin
        if (!QRT) begin
            r_filtLevel <= 1'b0;
            r_filtCnt   <= '0;
        end else if (!w_differ) begin
            r_filtCnt   <= '0;
        end else if (w_update) begin
            r_filtLevel <= w_syncLevel;
            r_filtCnt   <= '0;
        end else begin
            r_filtCnt   <= r_filtCnt + CNT_W'(1);
        end
    end

    // An accept frees the slot in the same cycle, so a new event may load
    // on that edge; otherwise a new event against a full slot is lost.
    assign w_accept   = r_edgeVld && bus.EDGE_RDY;
    assign w_overflow = w_update && r_edgeVld && !bus.EDGE_RDY;

    // Single-entry event buffer; the pending event is frozen until accepted.
    always_ff @(posedge IQC or negedge QRT) begin
        if (!QRT) begin
            r_edgeVld  <= 1'b0;
            r_edgeRise <= 1'b0;
        end else if (w_update && (!r_edgeVld || bus.EDGE_RDY)) begin
            r_edgeVld  <= 1'b1;
            r_edgeRise <= w_syncLevel;
        end else if (w_accept) begin
            r_edgeVld  <= 1'b0;
        end
    end

    // Sticky overflow; a fresh overflow takes priority over a clear request.
    always_ff @(posedge IQC or negedge QRT) begin
        if (!QRT) begin
            r_edgeOvf <= 1'b0;
        end else if (w_overflow) begin
            r_edgeOvf <= 1'b1;
        end else if (bus.OVF_CLR) begin
            r_edgeOvf <= 1'b0;
        end
    end

    // Output mux is fed only by flops, never by the raw pad.
    assign bus.A2F       = bus.ISEL ? r_filtLevel : w_syncLevel;
    assign bus.EDGE_VLD  = r_edgeVld;
    assign bus.EDGE_RISE = r_edgeRise;
    assign bus.EDGE_OVF  = r_edgeOvf;

endmodule

// File: tb/tb_in_filter_reg_cell.sv
// ----------------------------------------------------------------------------
// tb_in_filter_reg_cell
// Randomized bench for in_filter_reg_cell with a reference model and an
// event scoreboard. Inputs change 2 time units after the rising edge; the
// monitor samples on the falling edge.
// ----------------------------------------------------------------------------
module tb_in_filter_reg_cell;

    localparam int FILT_LEN = 4;
    localparam int CNT_W    = 4;

    logic IQC;
    logic QRT;

    in_filter_reg_cell_if bus ();

    in_filter_reg_cell #(
        .FILT_LEN (FILT_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .IQC (IQC),
        .QRT (QRT),
        .bus (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state
    bit       mS1, mS2, mFl, mVld, mOvf;
    bit       windowHit, ovfNow;
    bit [1:0] hist[$];
    bit       expQ[$];
    bit       iqiLevel;

    // Free-running clock
    initial begin
        IQC = 1'b0;
        forever #5 IQC = ~IQC;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitCycle();
        @(posedge IQC);
        #2;
    endtask

    // Reference model. The filtered level follows the synchronized pad once
    // the last FILT_LEN synchronized samples were all captured with IEN=1
    // and all differ from the current level. Events that reach the buffer
    // are queued for the scoreboard.
    always @(posedge IQC or negedge QRT) begin
        if (!QRT) begin
            mS1 = 0; mS2 = 0; mFl = 0; mVld = 0; mOvf = 0;
            hist.delete();
            expQ.delete();
        end else begin
            hist.push_back({bus.IEN, mS2});
            if (hist.size() > FILT_LEN) void'(hist.pop_front());
            windowHit = (hist.size() == FILT_LEN);
            foreach (hist[k])
                if (hist[k][1] == 1'b0 || hist[k][0] == mFl) windowHit = 1'b0;
            ovfNow = 1'b0;
            if (windowHit) begin
                mFl = mS2;
                if (!mVld || bus.EDGE_RDY) begin
                    expQ.push_back(mFl);
                    mVld = 1'b1;
                end else begin
                    ovfNow = 1'b1;
                end
            end else if (mVld && bus.EDGE_RDY) begin
                mVld = 1'b0;
            end
            if (ovfNow) mOvf = 1'b1;
            else if (bus.OVF_CLR) mOvf = 1'b0;
            mS2 = mS1;
            mS1 = bus.IQI;
        end
    end

    // Monitor: compares levels every cycle and checks each presented event
    // against the scoreboard, popping it when the fabric accepts it.
    always @(negedge IQC) begin
        checkOutput("a2f", bus.A2F, bus.ISEL ? mFl : mS2);
        checkOutput("edge_vld", bus.EDGE_VLD, mVld);
        checkOutput("edge_ovf", bus.EDGE_OVF, mOvf);
        if (bus.EDGE_VLD === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("event_unexpected", 32'd1, 32'd0);
            end else begin
                checkOutput("edge_rise", bus.EDGE_RISE, expQ[0]);
                if (bus.EDGE_RDY) void'(expQ.pop_front());
            end
        end
    end

    // Asynchronous reset pulse in the middle of a cycle
    task automatic doReset();
        @(posedge IQC);
        #3 QRT = 1'b0;
        #1;
        checkOutput("rst_a2f", bus.A2F, 1'b0);
        checkOutput("rst_vld", bus.EDGE_VLD, 1'b0);
        checkOutput("rst_rise", bus.EDGE_RISE, 1'b0);
        checkOutput("rst_ovf", bus.EDGE_OVF, 1'b0);
        @(posedge IQC);
        #2 QRT = 1'b1;
    endtask

    // Random pad activity with runs of varying length, mostly enabled
    // capture, random output select, back-pressure and overflow clears.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 399) == 0) doReset();
            else waitCycle();
            if ($urandom_range(0, 5) == 0) iqiLevel = ~iqiLevel;
            bus.IQI      = iqiLevel;
            bus.IEN      = ($urandom_range(0, 9) != 0);
            bus.ISEL     = 1'($urandom_range(0, 1));
            bus.EDGE_RDY = ($urandom_range(0, 2) == 0);
            bus.OVF_CLR  = ($urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        QRT          = 1'b0;
        iqiLevel     = 1'b0;
        bus.IQI      = 1'b0;
        bus.IEN      = 1'b1;
        bus.ISEL     = 1'b1;
        bus.EDGE_RDY = 1'b0;
        bus.OVF_CLR  = 1'b0;
        #1;
        checkOutput("reset_a2f", bus.A2F, 1'b0);
        checkOutput("reset_vld", bus.EDGE_VLD, 1'b0);
        repeat (3) waitCycle();
        QRT = 1'b1;
        repeat (3) waitCycle();

        // Held rising pad: filtered level and event appear on the 6th edge
        bus.IQI  = 1'b1;
        iqiLevel = 1'b1;
        repeat (5) waitCycle();
        checkOutput("lat_a2f_early", bus.A2F, 1'b0);
        checkOutput("lat_vld_early", bus.EDGE_VLD, 1'b0);
        waitCycle();
        checkOutput("lat_a2f", bus.A2F, 1'b1);
        checkOutput("lat_vld", bus.EDGE_VLD, 1'b1);
        checkOutput("lat_rise", bus.EDGE_RISE, 1'b1);

        applyStimulus(1500);
        doReset();
        applyStimulus(1500);

        // Drain: no new events, fabric accepts whatever is pending
        bus.IEN      = 1'b0;
        bus.EDGE_RDY = 1'b1;
        repeat (4) waitCycle();
        checkOutput("drain_empty", expQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
